// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the fetch handshake: word-addressed RAM,
// one outstanding chip-select read, response after WAIT_CYCLES wait-states,
// abort on flush, and a load port that can write the RAM in any state.
// Optional out-of-range check: define IMEM_RANGE_CHK_EN.
module imem_fetch_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_cs,
  input  logic [31:0]   req_addr,
  output logic          req_ready,
  input  logic          flush,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          rsp_err
);

  localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic [31:0]   mem_q [DEPTH];

  // Byte offset from the base; the extra top bit is the borrow (addr below base).
  logic [32:0]   req_off;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] rd_idx;
  logic          accept;
  logic          load_rsp;
  logic          unused_addr_bits;

  assign req_off = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign req_idx = req_off[AW+1:2];
  assign unused_addr_bits = ^{req_off[1:0], req_off[32:AW+2]};

`ifdef IMEM_RANGE_CHK_EN
  logic oor_q, oor_d, req_oor, rd_oor;
  assign req_oor = req_off[32] || ({2'b00, req_off[31:2]} >= 32'(DEPTH));
`endif

  // Next-state, accept decision and response-data capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rsp_data_d = rsp_data_q;
    accept     = 1'b0;
    load_rsp   = 1'b0;
    rd_idx     = idx_q;
`ifdef IMEM_RANGE_CHK_EN
    oor_d  = oor_q;
    rd_oor = oor_q;
`endif
    unique case (state_q)
      StIdle, StResp: begin
        if (req_cs && !flush) accept = 1'b1;
        else state_d = StIdle;
      end
      StWait: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d  = StResp;
          load_rsp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      idx_d = req_idx;
`ifdef IMEM_RANGE_CHK_EN
      oor_d = req_oor;
`endif
      if (WAIT_CYCLES == 0) begin
        // Zero wait-states: read straight from the request address.
        state_d  = StResp;
        load_rsp = 1'b1;
        rd_idx   = req_idx;
`ifdef IMEM_RANGE_CHK_EN
        rd_oor   = req_oor;
`endif
      end else begin
        state_d = StWait;
        cnt_d   = WaitInit;
      end
    end

    if (load_rsp) begin
`ifdef IMEM_RANGE_CHK_EN
      rsp_data_d = rd_oor ? NopInstr : mem_q[rd_idx];
`else
      rsp_data_d = mem_q[rd_idx];
`endif
    end
  end

  // Control and response registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      rsp_data_q <= 32'h0;
`ifdef IMEM_RANGE_CHK_EN
      oor_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rsp_data_q <= rsp_data_d;
`ifdef IMEM_RANGE_CHK_EN
      oor_q      <= oor_d;
`endif
    end
  end

  // RAM write port; not reset so it can be filled while rst_n is low.
  // The response read above sees the pre-write word on the same edge.
  always_ff @(posedge clk) begin
    if (ld_we) mem_q[ld_addr] <= ld_wdata;
  end

  assign req_ready = (state_q != StWait);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
`ifdef IMEM_RANGE_CHK_EN
  assign rsp_err   = (state_q == StResp) && oor_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: one instance with two wait-states and one
// with none; responses are scored against a queue of expected {err, data}.
module tb_imem_fetch_responder;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Aw    = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [Aw-1:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;

  logic        req_cs2 = 1'b0, flush2 = 1'b0, ld_we2 = 1'b0;
  logic [31:0] req_addr2 = '0;
  logic        req_ready2, rsp_valid2, rsp_err2;
  logic [31:0] rsp_data2;

  logic        req_cs0 = 1'b0, flush0 = 1'b0, ld_we0 = 1'b0;
  logic [31:0] req_addr0 = '0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_data0;

  logic [32:0] q2[$];
  logic [32:0] q0[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  imem_fetch_responder #(.DEPTH(Depth), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_cs(req_cs2), .req_addr(req_addr2),
    .req_ready(req_ready2), .flush(flush2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .ld_we(ld_we2), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .rsp_err(rsp_err2)
  );

  imem_fetch_responder #(.DEPTH(Depth), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_cs(req_cs0), .req_addr(req_addr0),
    .req_ready(req_ready0), .flush(flush0), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0),
    .ld_we(ld_we0), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .rsp_err(rsp_err0)
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboards: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid2) begin
      if (q2.size() == 0) check("rsp2_unexpected", {rsp_err2, rsp_data2}, 33'h0);
      else check("rsp2_data", {rsp_err2, rsp_data2}, q2.pop_front());
    end
    if (rst_n && rsp_valid0) begin
      if (q0.size() == 0) check("rsp0_unexpected", {rsp_err0, rsp_data0}, 33'h0);
      else check("rsp0_data", {rsp_err0, rsp_data0}, q0.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch on the two-wait instance and check its latency.
  task automatic fetch2(input logic [31:0] addr, input logic [32:0] exp);
    int lat;
    lat = 0;
    req_cs2 = 1'b1;
    req_addr2 = addr;
    q2.push_back(exp);
    step();
    req_cs2 = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (rsp_valid2) lat = i;
    end
    check("fetch_latency", 33'(lat), 33'd3);
    step();
  endtask

  initial begin
    int nvalid;
    // Fill words 0..3 while reset is still asserted.
    for (int i = 0; i < 4; i++) begin
      ld_we2 = 1'b1; ld_we0 = 1'b1;
      ld_addr = Aw'(i); ld_wdata = 32'hA0 + 32'(i);
      step();
    end
    ld_we2 = 1'b0; ld_we0 = 1'b0;
    @(negedge clk);
    check("reset_ready", 33'(req_ready2), 33'd1);
    check("reset_valid", 33'(rsp_valid2), 33'd0);
    check("reset_data_err", {rsp_err2, rsp_data2}, 33'h0);
    step();
    rst_n = 1'b1;
    step();

    // 1: fetch 0x8 with two wait-states, cycle by cycle.
    req_cs2 = 1'b1; req_addr2 = 32'h8; q2.push_back({1'b0, 32'hA2});
    step();
    req_cs2 = 1'b0;
    @(negedge clk);
    check("t1_n1_ready", 33'(req_ready2), 33'd0);
    check("t1_n1_valid", 33'(rsp_valid2), 33'd0);
    @(negedge clk);
    check("t1_n2_ready", 33'(req_ready2), 33'd0);
    check("t1_n2_valid", 33'(rsp_valid2), 33'd0);
    @(negedge clk);
    check("t1_n3_valid", 33'(rsp_valid2), 33'd1);
    check("t1_n3_ready", 33'(req_ready2), 33'd1);
    @(negedge clk);
    check("t1_n4_valid", 33'(rsp_valid2), 33'd0);
    check("t1_data_hold", 33'(rsp_data2), 33'hA2);
    step();

    // 2: zero wait-states, req_cs held on 0x0, 0x4, 0x8.
    req_cs0 = 1'b1; req_addr0 = 32'h0;
    for (int i = 0; i < 3; i++) q0.push_back({1'b0, 32'hA0 + 32'(i)});
    for (int i = 0; i < 3; i++) begin
      step();
      req_addr0 = 32'(i + 1) * 4;
      if (i == 2) req_cs0 = 1'b0;
      @(negedge clk);
      check("t2_b2b_valid", 33'(rsp_valid0), 33'd1);
    end
    step();
    @(negedge clk);
    check("t2_after_valid", 33'(rsp_valid0), 33'd0);
    step();

    // 3: flush in the first wait cycle aborts the fetch.
    req_cs2 = 1'b1; req_addr2 = 32'h4;
    step();
    req_cs2 = 1'b0; flush2 = 1'b1;
    step();
    flush2 = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid2) nvalid++;
      if (i == 0) check("t3_idle_ready", 33'(req_ready2), 33'd1);
    end
    check("t3_no_rsp", 33'(nvalid), 33'd0);
    step();
    fetch2(32'hC, {1'b0, 32'hA3});

    // 4: flush together with req_cs in idle drops the request.
    req_cs2 = 1'b1; flush2 = 1'b1; req_addr2 = 32'h0;
    @(negedge clk);
    check("t4_ready_during_flush", 33'(req_ready2), 33'd1);
    step();
    req_cs2 = 1'b0; flush2 = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid2) nvalid++;
    end
    check("t4_no_rsp", 33'(nvalid), 33'd0);
    step();

    // 5: load on the edge entering RESP returns the old word.
    req_cs2 = 1'b1; req_addr2 = 32'h4; q2.push_back({1'b0, 32'hA1});
    step();
    req_cs2 = 1'b0;
    step();
    ld_we2 = 1'b1; ld_addr = Aw'(1); ld_wdata = 32'hBEEF;
    step();
    ld_we2 = 1'b0;
    @(negedge clk);
    check("t5_rbw_valid", 33'(rsp_valid2), 33'd1);
    step();
    fetch2(32'h4, {1'b0, 32'hBEEF});

    // 6: asynchronous reset mid-wait.
    req_cs2 = 1'b1; req_addr2 = 32'h0;
    step();
    req_cs2 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 33'(rsp_valid2), 33'd0);
    check("t6_rst_ready", 33'(req_ready2), 33'd1);
    check("t6_rst_data", 33'(rsp_data2), 33'h0);
    step();
    rst_n = 1'b1;
    step();
`ifdef IMEM_RANGE_CHK_EN
    fetch2(32'h1000, {1'b1, 32'h13});
`else
    // Without the range check the index wraps to word 0.
    fetch2(32'h1000, {1'b0, 32'hA0});
`endif
    fetch2(32'h8, {1'b0, 32'hA2});

    repeat (3) step();
    check("q2_drained", 33'(q2.size()), 33'd0);
    check("q0_drained", 33'(q0.size()), 33'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
